// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes and monitor states for the
// traffic-light safety path.
package traffic_pkg;

  localparam logic [2:0]  LAMP_GREEN  = 3'b100;
  localparam logic [2:0]  LAMP_YELLOW = 3'b010;
  localparam logic [2:0]  LAMP_RED    = 3'b001;
  localparam logic [11:0] ALL_RED     = {4{LAMP_RED}};
  localparam int          NUM_GROUPS  = 4;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_BAD_ENC  = 3'd1,
    FC_CONFLICT = 3'd2,
    FC_STUCK    = 3'd3
  } fault_code_t;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    FAULT   = 2'd1,
    RECOVER = 2'd2
  } mon_state_t;

  // A group is well formed only if exactly one of its three lamps is lit.
  function automatic logic lamp_valid(input logic [2:0] grp);
    return (grp == LAMP_GREEN) || (grp == LAMP_YELLOW) || (grp == LAMP_RED);
  endfunction

endpackage

// File: rtl/traffic_flash_gen.sv
// Fail-safe flash phase generator: restart forces the "reds lit" phase,
// enable lets the phase toggle every FLASH_HALF cycles, otherwise idle dark.
module traffic_flash_gen
  import traffic_pkg::*;
#(
  parameter int FLASH_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic phase
);

  localparam int FC_W = $clog2(FLASH_HALF + 1);

  logic [FC_W-1:0] r_fc;
  logic            r_phase;

  // Half-period counter and phase toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fc    <= '0;
      r_phase <= 1'b0;
    end else if (restart) begin
      r_fc    <= '0;
      r_phase <= 1'b1;
    end else if (enable) begin
      if (32'(r_fc) >= FLASH_HALF - 1) begin
        r_fc    <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fc <= r_fc + FC_W'(1);
      end
    end else begin
      r_fc    <= '0;
      r_phase <= 1'b0;
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety monitor between the light controller and the lamp drivers.
// Registers the controller bus, checks encoding / right-of-way / liveness,
// passes legal patterns through and falls back to a flashing all-red.
module light_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int CONFLICT_CYCLES = 2,
  parameter int STUCK_CYCLES    = 255,
  parameter int FLASH_HALF      = 4,
  parameter int RECOVER_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] light_in,
  input  logic        fault_clr,
  output logic [11:0] lamp_out,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        flash
);

  localparam int SC_W = $clog2(STUCK_CYCLES + 1);
  localparam int RC_W = $clog2(RECOVER_CYCLES + 1);

  logic [11:0]     r_in_q, r_prev_q, r_lamp;
  mon_state_t      r_state;
  fault_code_t     r_code;
  logic [3:0]      r_pc;
  logic [SC_W-1:0] r_sc;
  logic [RC_W-1:0] r_rc;

  logic [NUM_GROUPS-1:0] w_grp_bad, w_grp_lit;
  logic w_v1, w_v2, w_v3, w_viol, w_same, w_pc_trig, w_clr_ok;
  logic w_restart, w_flash_en, w_pc_clr, w_sc_clr, w_phase;
  mon_state_t      w_state_next;
  fault_code_t     w_code_next;
  logic [RC_W-1:0] w_rc_next;

  // Per-group decode; "lit" only matters once every group is well formed.
  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
    assign w_grp_bad[gi] = !lamp_valid(r_in_q[gi*3 +: 3]);
    assign w_grp_lit[gi] = (r_in_q[gi*3 +: 3] != LAMP_RED);
  end

  assign w_v1      = |w_grp_bad;
  assign w_v2      = !w_v1 && ((w_grp_lit & (w_grp_lit - 4'd1)) != 4'd0);
  assign w_viol    = w_v1 || w_v2;
  assign w_same    = (r_in_q == r_prev_q);
  assign w_pc_trig = w_viol && ((32'(r_pc) + 1) >= CONFLICT_CYCLES);
  assign w_v3      = w_same && ((32'(r_sc) + 1) >= STUCK_CYCLES);
  assign w_clr_ok  = fault_clr && !w_viol;

  // Next-state and side-effect decisions for the monitor FSM.
  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_rc_next    = '0;
    w_restart    = 1'b0;
    w_flash_en   = 1'b0;
    w_pc_clr     = 1'b0;
    w_sc_clr     = 1'b0;
    case (r_state)
      MONITOR: begin
        if (w_pc_trig || w_v3) begin
          w_state_next = FAULT;
          w_code_next  = w_v1 ? FC_BAD_ENC : (w_v2 ? FC_CONFLICT : FC_STUCK);
          w_restart    = 1'b1;
        end
      end
      FAULT: begin
        if (w_clr_ok) begin
          // A clear beats a simultaneous stuck detection.
          w_state_next = RECOVER;
          w_sc_clr     = 1'b1;
        end else begin
          w_flash_en = 1'b1;
        end
      end
      RECOVER: begin
        if (w_viol) begin
          w_state_next = FAULT;
          w_code_next  = w_v1 ? FC_BAD_ENC : FC_CONFLICT;
          w_restart    = 1'b1;
        end else if (32'(r_rc) >= RECOVER_CYCLES - 1) begin
          w_state_next = MONITOR;
          w_code_next  = FC_NONE;
          w_pc_clr     = 1'b1;
          w_sc_clr     = 1'b1;
        end else begin
          w_rc_next = r_rc + RC_W'(1);
        end
      end
      default: w_state_next = MONITOR;
    endcase
  end

  // State, input pipeline and persistence / stuck counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= MONITOR;
      r_code   <= FC_NONE;
      r_in_q   <= ALL_RED;
      r_prev_q <= ALL_RED;
      r_lamp   <= ALL_RED;
      r_pc     <= '0;
      r_sc     <= '0;
      r_rc     <= '0;
    end else begin
      r_state  <= w_state_next;
      r_code   <= w_code_next;
      r_in_q   <= light_in;
      r_prev_q <= r_in_q;
      r_lamp   <= w_viol ? ALL_RED : r_in_q;
      r_rc     <= w_rc_next;
      if (w_pc_clr || !w_viol)
        r_pc <= '0;
      else if (32'(r_pc) < CONFLICT_CYCLES)
        r_pc <= r_pc + 4'd1;
      if (w_sc_clr || !w_same)
        r_sc <= '0;
      else if (32'(r_sc) < STUCK_CYCLES)
        r_sc <= r_sc + SC_W'(1);
    end
  end

  traffic_flash_gen #(
    .FLASH_HALF(FLASH_HALF)
  ) u_flash (
    .clk    (clk),
    .rst    (rst),
    .enable (w_flash_en),
    .restart(w_restart),
    .phase  (w_phase)
  );

  // Lamp selection: pass-through in MONITOR, flashing reds in FAULT,
  // solid reds while recovering.
  always_comb begin
    case (r_state)
      MONITOR: lamp_out = r_lamp;
      FAULT:   lamp_out = w_phase ? ALL_RED : 12'h000;
      default: lamp_out = ALL_RED;
    endcase
  end

  assign fault      = (r_state != MONITOR);
  assign fault_code = r_code;
  assign flash      = w_phase;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Directed bench for light_conflict_monitor with hand-computed expectations.
module tb_light_conflict_monitor;

  localparam logic [11:0] ALL_RED_V = 12'b001_001_001_001;
  localparam logic [11:0] G_A   = 12'b100_001_001_001;
  localparam logic [11:0] Y_A   = 12'b010_001_001_001;
  localparam logic [11:0] G_B   = 12'b001_100_001_001;
  localparam logic [11:0] CONF  = 12'b100_100_001_001;
  localparam logic [11:0] BAD1  = 12'b110_001_001_001;
  localparam logic [11:0] BAD0  = 12'b000_001_001_001;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] light_in;
  logic        fault_clr;
  logic [11:0] lamp_out;
  logic        fault;
  logic [2:0]  fault_code;
  logic        flash;

  int n_tests = 0;
  int n_fail  = 0;

  light_conflict_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .light_in  (light_in),
    .fault_clr (fault_clr),
    .lamp_out  (lamp_out),
    .fault     (fault),
    .fault_code(fault_code),
    .flash     (flash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    light_in = ALL_RED_V;
    fault_clr = 1'b0;
    ticks(3);
    chk("rst_lamp", lamp_out, ALL_RED_V);
    chk("rst_fault", {11'd0, fault}, 12'd0);
    chk("rst_code", {9'd0, fault_code}, 12'd0);
    chk("rst_flash", {11'd0, flash}, 12'd0);
    rst = 1'b0;

    // Pass-through with two-cycle latency
    light_in = G_A;
    tick();
    chk("t1_lat1", lamp_out, ALL_RED_V);
    tick();
    chk("t1_lat2", lamp_out, G_A);
    for (int i = 0; i < 18; i++) begin
      tick();
      chk("t1_hold_fault", {11'd0, fault}, 12'd0);
    end
    light_in = Y_A;
    tick();
    chk("t1_y_lat1", lamp_out, G_A);
    tick();
    chk("t1_y_lat2", lamp_out, Y_A);

    // Single-cycle conflict is filtered
    light_in = CONF;
    tick();
    light_in = Y_A;
    tick();
    chk("t2_blip_lamp", lamp_out, ALL_RED_V);
    chk("t2_blip_fault", {11'd0, fault}, 12'd0);
    tick();
    chk("t2_after_lamp", lamp_out, Y_A);
    chk("t2_after_fault", {11'd0, fault}, 12'd0);

    // Persistent bad encoding latches code 1
    light_in = BAD1;
    ticks(2);
    chk("t3_pre_fault", {11'd0, fault}, 12'd0);
    tick();
    chk("t3_fault", {11'd0, fault}, 12'd1);
    chk("t3_code", {9'd0, fault_code}, 12'd1);
    chk("t3_flash", {11'd0, flash}, 12'd1);
    chk("t3_lamp", lamp_out, ALL_RED_V);

    // Clear with an illegal input is ignored and not remembered
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("t5_ign_fault", {11'd0, fault}, 12'd1);
    chk("t5_ign_code", {9'd0, fault_code}, 12'd1);
    light_in = G_A;
    ticks(2);
    chk("t5_nomem_fault", {11'd0, fault}, 12'd1);
    chk("t5_flash_hi", {11'd0, flash}, 12'd1);
    tick();
    chk("t5_flash_lo", {11'd0, flash}, 12'd0);
    chk("t5_lamp_dark", lamp_out, 12'h000);

    // Legal clear enters RECOVER
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("t5_rec_fault", {11'd0, fault}, 12'd1);
    chk("t5_rec_flash", {11'd0, flash}, 12'd0);
    chk("t5_rec_lamp", lamp_out, ALL_RED_V);
    chk("t5_rec_code", {9'd0, fault_code}, 12'd1);

    // Conflict during RECOVER goes straight back to FAULT with code 2
    light_in = CONF;
    tick();
    chk("t5_rc_lamp", lamp_out, ALL_RED_V);
    tick();
    chk("t5_refault_code", {9'd0, fault_code}, 12'd2);
    chk("t5_refault_flash", {11'd0, flash}, 12'd1);
    chk("t5_refault_fault", {11'd0, fault}, 12'd1);

    // Flash half-period of 4 cycles
    ticks(3);
    chk("t2_flash_g3", lamp_out, ALL_RED_V);
    tick();
    chk("t2_flash_g4", lamp_out, 12'h000);
    chk("t2_flash_g4f", {11'd0, flash}, 12'd0);
    ticks(3);
    chk("t2_flash_g7", lamp_out, 12'h000);
    tick();
    chk("t2_flash_g8", lamp_out, ALL_RED_V);
    chk("t2_flash_g8f", {11'd0, flash}, 12'd1);

    // Clear, 8 cycles solid red, then pass-through
    light_in = G_A;
    tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    ticks(7);
    chk("t5_r7_lamp", lamp_out, ALL_RED_V);
    chk("t5_r7_fault", {11'd0, fault}, 12'd1);
    chk("t5_r7_code", {9'd0, fault_code}, 12'd2);
    tick();
    chk("t5_mon_fault", {11'd0, fault}, 12'd0);
    chk("t5_mon_code", {9'd0, fault_code}, 12'd0);
    chk("t5_mon_lamp", lamp_out, G_A);
    light_in = Y_A;
    ticks(2);
    chk("t5_mon_pass", lamp_out, Y_A);

    // Async reset mid-flash
    light_in = CONF;
    ticks(3);
    chk("t6_fault_code", {9'd0, fault_code}, 12'd2);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_lamp", lamp_out, ALL_RED_V);
    chk("t6_async_fault", {11'd0, fault}, 12'd0);
    chk("t6_async_code", {9'd0, fault_code}, 12'd0);
    chk("t6_async_flash", {11'd0, flash}, 12'd0);
    tick();
    light_in = G_A;
    rst = 1'b0;
    tick();
    chk("t6_lat1", lamp_out, ALL_RED_V);
    tick();
    chk("t6_pass", lamp_out, G_A);
    light_in = BAD0;
    ticks(2);
    chk("t3_z_pre", {11'd0, fault}, 12'd0);
    tick();
    chk("t3_z_code", {9'd0, fault_code}, 12'd1);

    // Toggling every 21 cycles never looks stuck
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      light_in = (k % 2 == 1) ? Y_A : G_A;
      ticks(21);
      chk("t4_toggle_fault", {11'd0, fault}, 12'd0);
    end

    // Constant input faults exactly when the stuck counter saturates
    light_in = G_B;
    tick();
    ticks(255);
    chk("t4_stuck_pre", {11'd0, fault}, 12'd0);
    tick();
    chk("t4_stuck_fault", {11'd0, fault}, 12'd1);
    chk("t4_stuck_code", {9'd0, fault_code}, 12'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
